// File: rtl/multicycle_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_shifter_if
// Brief    : Start/busy/data_ready handshake bundle for multicycle_shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               data_ready;

  modport master (
    output start, op, data_in, shamt,
    input  result, busy, data_ready
  );

  modport slave (
    input  start, op, data_in, shamt,
    output result, busy, data_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_shifter
// Brief    : Sequential SLL/SRL/SRA/ROL shifter, at most STEP bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  wire logic           clock,
  input  wire logic           reset,
  multicycle_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Amounts never exceed WIDTH-1, so a larger STEP behaves like WIDTH-1.
  localparam int                 c_STEP_CAP = (STEP > WIDTH - 1) ? WIDTH - 1 : STEP;
  localparam logic [SHAMT_W-1:0] c_STEP_N   = c_STEP_CAP[SHAMT_W-1:0];

  state_t             r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_remaining;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_ready;

  logic [SHAMT_W-1:0] w_n;
  logic [WIDTH-1:0]   w_shifted;

  assign w_n = (r_remaining < c_STEP_N) ? r_remaining : c_STEP_N;

  // SRA keeps the sign bit of r_work, which is the operand's original MSB.
  always_comb begin
    w_shifted = r_work;
    case (r_op)
      2'b00:   w_shifted = r_work << w_n;
      2'b01:   w_shifted = r_work >> w_n;
      2'b10:   w_shifted = $signed(r_work) >>> w_n;
      default: w_shifted = (r_work << w_n) | (r_work >> (WIDTH - int'(w_n)));
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_work      <= '0;
      r_remaining <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_work      <= w_shifted;
          r_remaining <= r_remaining - w_n;
          if (r_remaining == w_n) begin
            r_result <= w_shifted;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a request, so back-to-back has no bubble.
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (bus.start) begin
            r_op        <= bus.op;
            r_work      <= bus.data_in;
            r_remaining <= bus.shamt;
            if (bus.shamt == '0) begin
              r_result <= bus.data_in;
              r_state  <= S_DONE;
              r_ready  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.result     = r_result;
  assign bus.busy       = r_busy;
  assign bus.data_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_shifter
// Brief    : Directed bench for STEP=1 and STEP=4 shifters sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;

  int n_total = 0;
  int n_bad   = 0;

  multicycle_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus_a ();
  multicycle_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus_b ();

  assign bus_a.start   = start;
  assign bus_a.op      = op;
  assign bus_a.data_in = data_in;
  assign bus_a.shamt   = shamt;
  assign bus_b.start   = start;
  assign bus_b.op      = op;
  assign bus_b.data_in = data_in;
  assign bus_b.shamt   = shamt;

  multicycle_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  multicycle_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request to both DUTs and observe 40 cycles; optionally inject
  // a competing start at cycle inject_at while they are busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp,
                        input int exp_la, input int exp_lb, input int inject_at);
    int          la, lb, pulses, bad_busy, bad_hold;
    logic [31:0] prev;
    la = -1; lb = -1; pulses = 0; bad_busy = 0; bad_hold = 0;
    prev = bus_a.result;
    @(negedge clock);
    start = 1'b1; op = o; data_in = d; shamt = s;
    @(negedge clock);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus_a.data_ready) begin
        pulses++;
        if (la < 0) la = cyc;
      end
      if (bus_b.data_ready && lb < 0) lb = cyc;
      if (bus_a.busy !== (cyc < exp_la)) bad_busy++;
      if (la < 0 && bus_a.result !== prev) bad_hold++;
      if (cyc == inject_at) begin
        start = 1'b1; op = 2'b11; data_in = 32'h12345678; shamt = 5'd0;
      end
      @(negedge clock);
      start = 1'b0;
    end
    check({tag, " res_a"},   bus_a.result, exp);
    check({tag, " res_b"},   bus_b.result, exp);
    check({tag, " lat_a"},   la, exp_la);
    check({tag, " lat_b"},   lb, exp_lb);
    check({tag, " pulses"},  pulses, 1);
    check({tag, " busy"},    bad_busy, 0);
    check({tag, " hold"},    bad_hold, 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst busy_a",  bus_a.busy, 0);
    check("rst ready_a", bus_a.data_ready, 0);
    check("rst res_a",   bus_a.result, 0);
    check("rst busy_b",  bus_b.busy, 0);
    check("rst ready_b", bus_b.data_ready, 0);
    check("rst res_b",   bus_b.result, 0);

    //      tag          op     data_in        shamt  expected      La  Lb inject
    run_op("sll31",     2'b00, 32'h00000001, 5'd31, 32'h80000000, 32, 9, 0);
    run_op("sra4",      2'b10, 32'h80000000, 5'd4,  32'hF8000000, 5,  2, 0);
    run_op("srl4",      2'b01, 32'h80000000, 5'd4,  32'h08000000, 5,  2, 0);
    run_op("rol1",      2'b11, 32'h80000001, 5'd1,  32'h00000003, 2,  2, 0);
    run_op("rol31",     2'b11, 32'h80000001, 5'd31, 32'hC0000000, 32, 9, 0);
    run_op("zero",      2'b10, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1,  1, 0);
    run_op("sra8pos",   2'b10, 32'h7000000F, 5'd8,  32'h00700000, 9,  3, 0);
    run_op("srl31",     2'b01, 32'hF0000000, 5'd31, 32'h00000001, 32, 9, 0);
    run_op("sra31",     2'b10, 32'hF0000000, 5'd31, 32'hFFFFFFFF, 32, 9, 0);
    run_op("sll5",      2'b00, 32'hA5A5A5A5, 5'd5,  32'hB4B4B4A0, 6,  3, 0);
    run_op("rol8",      2'b11, 32'h12345678, 5'd8,  32'h34567812, 9,  3, 0);
    run_op("busyign",   2'b00, 32'h00000001, 5'd31, 32'h80000000, 32, 9, 5);

    // Back-to-back: new request presented during the DONE cycle
    @(negedge clock);
    start = 1'b1; op = 2'b01; data_in = 32'h80000000; shamt = 5'd2;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!bus_a.data_ready && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("b2b lat1", cyc, 3);
    check("b2b res1", bus_a.result, 32'h20000000);
    start = 1'b1; op = 2'b00; data_in = 32'h00000003; shamt = 5'd3;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!bus_a.data_ready && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("b2b lat2", cyc, 4);
    check("b2b res2", bus_a.result, 32'h00000018);
    repeat (40) @(negedge clock);

    // Reset in the middle of a 31-bit shift
    start = 1'b1; op = 2'b00; data_in = 32'h00000001; shamt = 5'd31;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("abort busy_pre", bus_a.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort busy",  bus_a.busy, 0);
    check("abort ready", bus_a.data_ready, 0);
    check("abort res_a", bus_a.result, 0);
    check("abort res_b", bus_b.result, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.data_ready) pulses++;
      @(negedge clock);
    end
    check("abort pulses", pulses, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_shifter.md
Name: multicycle_shifter

Overview:
- Parametrised sequential shifter for the CPU datapath.
- Supports logical left, logical right, arithmetic right and rotate-left by a variable amount.
- Shifts at most STEP bit positions per clock, so a small, cheap shift stage is reused over several cycles instead of a full barrel shifter.
- Connects to the execute stage through a start / busy / data_ready handshake, as the multdiv unit does.

Parameters:
- WIDTH, 32: data width in bits. Must equal 2^SHAMT_W.
- SHAMT_W, 5: width of the shift-amount port.
- STEP, 1: maximum bit positions shifted per cycle. Legal range 1..WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a shift. Accepted only on a rising edge where busy=0.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- data_in  input  WIDTH  operand. Sampled on the accepting edge only.
- shamt  input  SHAMT_W  shift amount, unsigned. Sampled on the accepting edge only.
- result  output  WIDTH  final shifted value.
- busy  output  1  high while a shift is in progress (state SHIFT).
- data_ready  output  1  one-cycle pulse: result is valid and just updated.

Behaviour:
- Reset is synchronous and active-high: on any rising edge with reset=1:
  - state <= IDLE
  - result <= 0
  - work register <= 0
  - remaining <= 0
  - busy = 0 and data_ready = 0 in the following cycle
  - reset overrides start and aborts any in-flight shift; the aborted operation never raises data_ready.
- States:
  - IDLE: busy=0, data_ready=0.
  - SHIFT: busy=1, data_ready=0.
  - DONE: busy=0, data_ready=1.
- Acceptance, on an edge in IDLE or DONE with start=1:
  - latch op, work <= data_in, remaining <= shamt.
  - If shamt==0: result <= data_in and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - n = min(STEP, remaining).
  - work <= work shifted by n according to op; remaining <= remaining - n.
  - If remaining - n == 0: result <= shifted work and go to DONE on the same edge.
- DONE: go to IDLE next edge, unless start=1, in which case accept the new request. Back-to-back operations are allowed with no idle bubble.
- Latency: start is sampled at the end of cycle 0; data_ready is high in cycle L = 1 + ceil(shamt/STEP).
  - STEP=1, shamt=31: L=32.
  - shamt=0: L=1.
- Start while busy=1 is ignored, including its data_in, shamt and op. The in-flight operation is unaffected.
- result:
  - changes only on the edge that enters DONE, or on reset;
  - holds between operations;
  - never shows intermediate values.
- Per-operation rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: each shifted-in bit equals the operand's original bit WIDTH-1.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Arithmetic rules:
  - remaining is SHAMT_W bits and never underflows, because n <= remaining.
  - shamt = WIDTH-1 is the maximum shift; no amount equals or exceeds WIDTH.
- op is held internally for the whole operation; later changes on the op port have no effect mid-shift.

Test Plan:
- SLL, data_in=0x00000001, shamt=31, STEP=1 -> data_ready pulses once in cycle 32; result=0x80000000; busy high in cycles 1..31.
- SRA, data_in=0x80000000, shamt=4 -> result=0xF8000000, L=5. SRL with the same inputs -> result=0x08000000.
- ROL, data_in=0x80000001, shamt=1 -> result=0x00000003, L=2. ROL by 31 -> result=0xC0000000.
- shamt=0, data_in=0xDEADBEEF, any op -> result=0xDEADBEEF with data_ready in cycle 1.
- Start with data_in=0x12345678 during busy=1 -> ignored, first result unchanged. Start asserted in the DONE cycle -> accepted, second result follows after its own L.
- Reset asserted at cycle 10 of a 31-bit shift -> next cycle busy=0, result=0, no data_ready pulse. STEP=4 instance, SLL 0x1 by 31 -> result=0x80000000, L=9.
